// File: rtl/mul_booth.sv
// ---------------------------------------------------------------------------
// mul_booth
//
// Sequential signed radix-2 Booth multiplier on the 8-bit shared-bus
// protocol used by the restoring divider. After a start request the host
// presents the multiplicand, then the multiplier, on inbus (one cycle each).
// One Booth step runs per clock for WIDTH clocks. The 2*WIDTH-bit product
// then comes back on outbus as high half, then low half. done is high
// together with the low half.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   enable  start request, honoured in IDLE
//           (and in OUT_LO, for back-to-back operation)
//   inbus   operand bus: multiplicand, then multiplier (two's complement)
//   done    one-cycle strobe concurrent with the product low half
//   outbus  product high half, then low half; zero otherwise
// ---------------------------------------------------------------------------
module mul_booth #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] inbus,
  output logic             done,
  output logic [WIDTH-1:0] outbus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_M,
    LOAD_Q,
    ITER,
    OUT_HI,
    OUT_LO
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] m_reg;
  logic [WIDTH:0]   a_reg;
  logic [WIDTH-1:0] q_reg;
  logic             q_m1;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   m_sext;
  logic [WIDTH:0]   a_sum;

  // Booth recoding of the current multiplier bit pair selects add, subtract
  // or pass-through. A carries one guard bit above the product width. That
  // keeps the subtraction of the most negative multiplicand from wrapping.
  always_comb begin
    m_sext = {m_reg[WIDTH-1], m_reg};
    a_sum  = a_reg;
    case ({q_reg[0], q_m1})
      2'b01:   a_sum = a_reg + m_sext;
      2'b10:   a_sum = a_reg - m_sext;
      default: a_sum = a_reg;
    endcase
  end

  // State register. Reset abandons any operation in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and Moore output decode.
  // outbus and done depend only on the registered state and datapath, so no
  // input reaches the outputs combinationally. Holding enable high through
  // OUT_LO chains the next operation straight into LOAD_M. That gives one
  // product every WIDTH+4 cycles.
  always_comb begin
    state_next = state;
    done       = 1'b0;
    outbus     = '0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next = LOAD_M;
        end
      end
      LOAD_M: state_next = LOAD_Q;
      LOAD_Q: state_next = ITER;
      ITER: begin
        if (cnt == LAST_STEP) begin
          state_next = OUT_HI;
        end
      end
      OUT_HI: begin
        outbus     = a_reg[WIDTH-1:0];
        state_next = OUT_LO;
      end
      OUT_LO: begin
        outbus     = q_reg;
        done       = 1'b1;
        state_next = enable ? LOAD_M : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers.
  // Operands are captured in the two load states. Each ITER cycle applies
  // the Booth add/subtract, then arithmetically shifts {A,Q,Q-1} right by
  // one. A's guard bit is replicated into the vacated MSB. After WIDTH
  // steps, {A[WIDTH-1:0],Q} holds the signed product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reg <= '0;
      a_reg <= '0;
      q_reg <= '0;
      q_m1  <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        LOAD_M: begin
          m_reg <= inbus;
        end
        LOAD_Q: begin
          q_reg <= inbus;
          a_reg <= '0;
          q_m1  <= 1'b0;
          cnt   <= '0;
        end
        ITER: begin
          a_reg <= {a_sum[WIDTH], a_sum[WIDTH:1]};
          q_reg <= {a_sum[0], q_reg[WIDTH-1:1]};
          q_m1  <= q_reg[0];
          cnt   <= cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_booth.sv
// ---------------------------------------------------------------------------
// tb_mul_booth
//
// Self-checking bench for mul_booth (WIDTH = 8). The driver starts
// operations and records, per clock cycle, what outbus and done must show.
// It derives those values from plain signed multiplication and the
// protocol's cycle offsets. Every other cycle must show zero on both
// outputs. A single compare process checks every cycle on the falling edge.
// Hand-computed products and latencies are pinned at specific cycles to
// anchor the model.
// ---------------------------------------------------------------------------
module tb_mul_booth;

  localparam int W    = 8;
  localparam int MAXC = 4096;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] inbus;
  logic       done;
  logic [7:0] outbus;

  int cyc        = 0;
  int cmp_count  = 0;
  int fail_count = 0;
  bit checking   = 1'b0;

  logic [7:0]  exp_bus   [MAXC];
  bit          exp_done  [MAXC];
  bit          lit_valid [MAXC];
  logic [15:0] lit_prod  [MAXC];
  logic [7:0]  prev_bus  = 8'h00;

  mul_booth #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .inbus  (inbus),
    .done   (done),
    .outbus (outbus)
  );

  // Free-running clock. Edge k leaves cyc == k.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One comparison, reported on mismatch.
  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] req);
    cmp_count++;
    if (act !== req) begin
      fail_count++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
               name, cyc, act, req);
    end
  endtask

  // Compare process.
  // Checks every cycle, away from the active edge. Pinned literal checks
  // verify done and the full product assembled from the previous cycle's
  // high half and the current low half.
  always @(negedge clk) begin
    if (checking && cyc < MAXC) begin
      checkOutput("outbus", {8'h00, outbus}, {8'h00, exp_bus[cyc]});
      checkOutput("done", {15'd0, done}, {15'd0, exp_done[cyc]});
      if (lit_valid[cyc]) begin
        checkOutput("pinned_done", {15'd0, done}, 16'd1);
        checkOutput("pinned_product", {prev_bus, outbus}, lit_prod[cyc]);
      end
    end
    prev_bus = outbus;
  end

  // Reference product: plain signed integer multiplication.
  function automatic logic [15:0] model_product(input logic [7:0] a,
                                                input logic [7:0] b);
    int x;
    int y;
    int p;
    x = int'($signed(a));
    y = int'($signed(b));
    p = x * y;
    return 16'(p);
  endfunction

  task automatic set_exp(input int idx, input logic [7:0] v, input bit d);
    if (idx >= 0 && idx < MAXC) begin
      exp_bus[idx]  = v;
      exp_done[idx] = d;
    end
  endtask

  task automatic set_lit(input int idx, input logic [15:0] v);
    if (idx >= 0 && idx < MAXC) begin
      lit_valid[idx] = 1'b1;
      lit_prod[idx]  = v;
    end
  endtask

  task automatic clear_from(input int idx);
    for (int i = idx; i < MAXC; i++) begin
      if (i >= 0) begin
        exp_bus[i]   = 8'h00;
        exp_done[i]  = 1'b0;
        lit_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic wait_edges(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Starts one operation and schedules its expected output.
  // The start edge s is the edge at which enable is sampled. The high half
  // shows after edge s+W+2, and the low half with done after edge s+W+3.
  // The task returns just after the multiplier-capture edge.
  task automatic applyStimulus(input logic [7:0] m, input logic [7:0] q,
                               input bit hold, output int s);
    logic [15:0] p;
    enable = 1'b1;
    @(posedge clk);
    #1;
    s = cyc;
    p = model_product(m, q);
    set_exp(s + W + 2, p[15:8], 1'b0);
    set_exp(s + W + 3, p[7:0], 1'b1);
    inbus  = m;
    enable = hold;
    @(posedge clk);
    #1;
    inbus = q;
    @(posedge clk);
    #1;
    inbus = 8'($urandom);
  endtask

  task automatic run_directed(input logic [7:0] m, input logic [7:0] q,
                              input logic [15:0] lit);
    int s;
    applyStimulus(m, q, 1'b0, s);
    set_lit(s + 11, lit);
    wait_edges(W + 2);
  endtask

  function automatic logic [7:0] pick_operand();
    logic [7:0] corners [4];
    corners[0] = 8'h80;
    corners[1] = 8'h7F;
    corners[2] = 8'h00;
    corners[3] = 8'hFF;
    if ($urandom_range(0, 3) == 0) begin
      return corners[$urandom_range(0, 3)];
    end
    return 8'($urandom);
  endfunction

  initial begin
    int s;
    int s1;
    int k;
    bit chain;
    logic [7:0] m;
    logic [7:0] q;

    clear_from(0);
    enable = 1'b0;
    inbus  = 8'h00;
    rst_n  = 1'b1;
    #2;
    rst_n  = 1'b0;
    #1;
    checking = 1'b1;
    wait_edges(3);
    rst_n = 1'b1;
    wait_edges(2);

    // Directed products with hand-computed values and 11-cycle latency.
    run_directed(8'h07, 8'h03, 16'h0015);
    run_directed(8'hFB, 8'h03, 16'hFFF1);
    run_directed(8'h80, 8'h80, 16'h4000);
    run_directed(8'h7F, 8'h80, 16'hC080);
    run_directed(8'h00, 8'h55, 16'h0000);

    // A start request during ITER must leave result and timing unchanged.
    applyStimulus(8'h07, 8'h03, 1'b0, s);
    set_lit(s + 11, 16'h0015);
    wait_edges(2);
    enable = 1'b1;
    wait_edges(1);
    enable = 1'b0;
    wait_edges(W - 1);

    // Back-to-back: with enable held, the second start edge is W+4 after the first.
    applyStimulus(8'h07, 8'h03, 1'b1, s1);
    set_lit(s1 + 11, 16'h0015);
    wait_edges(W + 1);
    applyStimulus(8'h02, 8'h02, 1'b0, s);
    set_lit(s1 + 23, 16'h0004);
    wait_edges(W + 2);

    // Reset asserted mid-ITER: outputs drop at once and no result follows.
    applyStimulus(8'h07, 8'h03, 1'b0, s);
    wait_edges(3);
    rst_n = 1'b0;
    clear_from(cyc);
    wait_edges(2);
    rst_n = 1'b1;
    wait_edges(W + 4);
    run_directed(8'h07, 8'h03, 16'h0015);

    // Randomized operands, with random chaining and stray enable pulses.
    for (int n = 0; n < 30; n++) begin
      m = pick_operand();
      q = pick_operand();
      chain = (n != 29) && ($urandom_range(0, 2) == 0);
      applyStimulus(m, q, chain, s);
      if (chain) begin
        wait_edges(W + 1);
      end else if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(1, W - 2);
        wait_edges(k);
        enable = 1'b1;
        wait_edges(1);
        enable = 1'b0;
        wait_edges(W + 1 - k);
      end else begin
        wait_edges(W + 2);
      end
    end

    wait_edges(4);
    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_count, fail_count);
    $finish;
  end

endmodule
